// File: rtl/servo_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// servo_cmd_ctrl
//
// Command front-end for the remote servo. Bytes from the UART receiver are
// parsed as 3-byte position frames (header 0xFF, angle A, check ~A). A valid
// angle is converted to a pulse width in clock ticks with a multicycle
// restoring divider. duty_cycle then slews toward that target by at most
// STEP_TICKS per PWM frame. duty_cycle only ever changes at a PWM frame
// boundary, so the downstream PWM never emits a truncated pulse.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rx_data     received byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   duty_cycle  high time in ticks, to the PWM stage
//   period      constant frame length in ticks, to the PWM stage
//   frame_start one-cycle pulse on the cycle duty_cycle may update
//   cmd_ok      one-cycle pulse when a new target is loaded
//   cmd_error   one-cycle pulse on a rejected frame or dropped byte
//   at_target   level, duty_cycle equals the current target
// ---------------------------------------------------------------------------
module servo_cmd_ctrl #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned PWM_FREQ   = 50,
    parameter int unsigned MIN_TICKS  = 25000,
    parameter int unsigned SPAN_TICKS = 25000,
    parameter int unsigned MAX_ANGLE  = 180,
    parameter int unsigned STEP_TICKS = 2500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] duty_cycle,
    output logic [31:0] period,
    output logic        frame_start,
    output logic        cmd_ok,
    output logic        cmd_error,
    output logic        at_target
);

    localparam logic [31:0] PERIOD_TICKS = 32'(CLK_FREQ / PWM_FREQ);
    localparam logic [31:0] MIN_T        = 32'(MIN_TICKS);
    localparam logic [31:0] SPAN_T       = 32'(SPAN_TICKS);
    localparam logic [31:0] STEP_T       = 32'(STEP_TICKS);
    localparam logic [31:0] CENTER_T     = 32'(MIN_TICKS + SPAN_TICKS / 2);
    localparam logic [7:0]  MAX_A        = 8'(MAX_ANGLE);
    localparam logic [32:0] DIVISOR      = 33'(MAX_ANGLE);
    localparam logic [7:0]  HEADER       = 8'hFF;
    localparam logic [5:0]  DIV_BITS     = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        ANGLE,
        CHECK,
        CALC
    } state_t;

    state_t      state;
    logic [7:0]  angle;
    logic [31:0] target;
    logic [31:0] frame_cnt;

    // Restoring divider working registers: the dividend is shifted out MSB
    // first into the partial remainder, one quotient bit per cycle.
    logic [31:0] dividend;
    logic [31:0] remainder;
    logic [31:0] quotient;
    logic [5:0]  bit_cnt;

    logic [31:0] product;
    logic        frame_valid;
    logic [32:0] rem_shift;
    logic        div_fits;
    logic [31:0] duty_next;

    // Frame validation and one divider step, evaluated from the current
    // registers. rem_shift is one bit wider than the remainder so the
    // shifted-in bit can never be lost before the trial subtraction.
    always_comb begin
        product     = {24'd0, angle} * SPAN_T;
        frame_valid = (angle <= MAX_A) && (rx_data == ~angle);
        rem_shift   = {remainder, dividend[31]};
        div_fits    = (rem_shift >= DIVISOR);
    end

    // Byte parser and divider sequencer. The check byte moves the FSM into
    // CALC with the product already loaded; CALC runs 32 divide steps and
    // one completion cycle, so cmd_ok appears 34 cycles after the check
    // byte. Bytes that arrive while CALC is busy are dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            angle     <= 8'd0;
            target    <= CENTER_T;
            dividend  <= 32'd0;
            remainder <= 32'd0;
            quotient  <= 32'd0;
            bit_cnt   <= 6'd0;
            cmd_ok    <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            cmd_ok    <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == HEADER)) begin
                        state <= ANGLE;
                    end
                end
                ANGLE: begin
                    // A repeated header keeps us waiting for the angle, which
                    // lets the parser resynchronise on a stream of 0xFF.
                    if (rx_valid && (rx_data != HEADER)) begin
                        angle <= rx_data;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (frame_valid) begin
                            dividend  <= product;
                            remainder <= 32'd0;
                            quotient  <= 32'd0;
                            bit_cnt   <= 6'd0;
                            state     <= CALC;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                CALC: begin
                    cmd_error <= rx_valid;
                    if (bit_cnt != DIV_BITS) begin
                        dividend  <= {dividend[30:0], 1'b0};
                        quotient  <= {quotient[30:0], div_fits};
                        remainder <= div_fits ? 32'(rem_shift - DIVISOR)
                                              : rem_shift[31:0];
                        bit_cnt   <= bit_cnt + 6'd1;
                    end else begin
                        target <= MIN_T + quotient;
                        cmd_ok <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Next duty value for the coming frame: move toward the target by at
    // most one step, never overshooting. Differences are compared instead of
    // sums so nothing can wrap near the ends of the 32-bit range.
    always_comb begin
        duty_next = duty_cycle;
        if (STEP_T == 32'd0) begin
            duty_next = target;
        end else if (duty_cycle < target) begin
            duty_next = ((target - duty_cycle) > STEP_T) ? (duty_cycle + STEP_T) : target;
        end else if (duty_cycle > target) begin
            duty_next = ((duty_cycle - target) > STEP_T) ? (duty_cycle - STEP_T) : target;
        end
    end

    // Frame counter mirrors the PWM stage's counter, which is released by
    // the same reset; duty_cycle is only updated on its wrap cycle. A target
    // loaded on that same edge is therefore seen one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= 32'd0;
            duty_cycle <= CENTER_T;
        end else begin
            if (frame_start) begin
                frame_cnt  <= 32'd0;
                duty_cycle <= duty_next;
            end else begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    assign frame_start = (frame_cnt == (PERIOD_TICKS - 32'd1));
    assign at_target   = (duty_cycle == target);
    assign period      = PERIOD_TICKS;

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_servo_cmd_ctrl
//
// Scoreboard bench for servo_cmd_ctrl. Stimulus pushes the expected command
// responses (cmd_ok with its target, or cmd_error) with the cycle on which
// they must appear; an independent monitor on the falling edge pops them,
// tracks the reference target and slewed duty, and compares every cycle.
// Two DUT copies share the inputs: one slew-limited, one with STEP_TICKS=0.
// A short PWM period keeps the run small; the arithmetic is unchanged.
// ---------------------------------------------------------------------------
module tb_servo_cmd_ctrl;

    localparam int unsigned CLK_FREQ   = 10000;
    localparam int unsigned PWM_FREQ   = 50;
    localparam int unsigned MIN_TICKS  = 25000;
    localparam int unsigned SPAN_TICKS = 25000;
    localparam int unsigned MAX_ANGLE  = 180;
    localparam int unsigned STEP_TICKS = 2500;
    localparam int unsigned PERIOD     = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CENTER     = MIN_TICKS + SPAN_TICKS / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;

    logic [31:0] duty_cycle, period;
    logic        frame_start, cmd_ok, cmd_error, at_target;
    logic [31:0] jmp_duty_cycle, jmp_period;
    logic        jmp_frame_start, jmp_cmd_ok, jmp_cmd_error, jmp_at_target;

    typedef struct {
        int unsigned cycle;
        int unsigned target;
    } okEntry_t;

    okEntry_t    okQ[$];
    int unsigned errQ[$];
    int unsigned cyc;
    int unsigned modelDuty, modelDuty0, modelTarget;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    servo_cmd_ctrl #(
        .CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .MIN_TICKS(MIN_TICKS),
        .SPAN_TICKS(SPAN_TICKS), .MAX_ANGLE(MAX_ANGLE), .STEP_TICKS(STEP_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .duty_cycle(duty_cycle), .period(period), .frame_start(frame_start),
        .cmd_ok(cmd_ok), .cmd_error(cmd_error), .at_target(at_target)
    );

    servo_cmd_ctrl #(
        .CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .MIN_TICKS(MIN_TICKS),
        .SPAN_TICKS(SPAN_TICKS), .MAX_ANGLE(MAX_ANGLE), .STEP_TICKS(0)
    ) dut_jump (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .duty_cycle(jmp_duty_cycle), .period(jmp_period), .frame_start(jmp_frame_start),
        .cmd_ok(jmp_cmd_ok), .cmd_error(jmp_cmd_error), .at_target(jmp_at_target)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycles since reset release; the PWM frame position is cyc mod PERIOD
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic int unsigned expectedTarget(input int unsigned a);
        return MIN_TICKS + (a * SPAN_TICKS) / MAX_ANGLE;
    endfunction

    function automatic int unsigned slewStep(input int unsigned d, input int unsigned t,
                                             input int unsigned s);
        if (s == 0) return t;
        if (d < t)  return (t - d > s) ? d + s : t;
        if (d > t)  return (d - t > s) ? d - s : t;
        return d;
    endfunction

    // Monitor: pops expected events due this cycle, compares the pulses and
    // the duty/target levels, then advances the reference duty at frame end.
    always @(negedge clk) begin
        bit expOk, expErr, expFs;
        if (!rst_n) begin
            modelDuty   = CENTER;
            modelDuty0  = CENTER;
            modelTarget = CENTER;
            okQ.delete();
            errQ.delete();
        end else begin
            expOk  = (okQ.size() > 0) && (okQ[0].cycle == cyc);
            expErr = (errQ.size() > 0) && (errQ[0] == cyc);
            expFs  = ((cyc % PERIOD) == PERIOD - 1);
            if (expOk) begin
                modelTarget = okQ[0].target;
                void'(okQ.pop_front());
            end
            if (expErr) void'(errQ.pop_front());
            if (cmd_ok || jmp_cmd_ok || expOk) begin
                checkOutput("cmd_ok", cmd_ok, expOk);
                checkOutput("jump_cmd_ok", jmp_cmd_ok, expOk);
            end
            if (cmd_error || jmp_cmd_error || expErr) begin
                checkOutput("cmd_error", cmd_error, expErr);
                checkOutput("jump_cmd_error", jmp_cmd_error, expErr);
            end
            if (frame_start || jmp_frame_start || expFs) begin
                checkOutput("frame_start", frame_start, expFs);
                checkOutput("jump_frame_start", jmp_frame_start, expFs);
                checkOutput("period", period, PERIOD);
                checkOutput("jump_period", jmp_period, PERIOD);
            end
            checkOutput("duty_cycle", duty_cycle, modelDuty);
            checkOutput("at_target", at_target, modelDuty == modelTarget);
            checkOutput("jump_duty_cycle", jmp_duty_cycle, modelDuty0);
            checkOutput("jump_at_target", jmp_at_target, modelDuty0 == modelTarget);
            if (expFs) begin
                modelDuty  = slewStep(modelDuty, modelTarget, STEP_TICKS);
                modelDuty0 = slewStep(modelDuty0, modelTarget, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte strobe; returns the cycle in which the DUT samples it
    task automatic sendByte(input logic [7:0] b, output int unsigned c0);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic waitFrames(input int n);
        repeat (n) begin
            do @(negedge clk); while ((cyc % PERIOD) != PERIOD - 1);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Sends nHeaders x 0xFF, then A, then C. The outcome is decided from the
    // frame rules alone; dropAt >= 2 also injects a byte that many cycles
    // after the check byte of a valid frame (it must be dropped and flagged).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c,
                                 input int nHeaders, input int dropAt);
        int unsigned c0, dummy;
        okEntry_t    e;
        bit          valid;
        valid = (a <= 8'(MAX_ANGLE)) && (c == ~a);
        for (int h = 0; h < nHeaders; h++) sendByte(8'hFF, dummy);
        sendByte(a, dummy);
        c0 = cyc + 1;
        if (valid) begin
            e.cycle  = c0 + 34;
            e.target = expectedTarget(int'(a));
            okQ.push_back(e);
        end else begin
            errQ.push_back(c0 + 1);
        end
        sendByte(c, dummy);
        if (valid) begin
            if (dropAt >= 2) begin
                repeat (dropAt - 2) @(negedge clk);
                errQ.push_back(cyc + 2);
                sendByte(8'($urandom), dummy);
            end
            while (cyc < c0 + 36) @(negedge clk);
        end else begin
            idle(2);
        end
    endtask

    initial begin
        int unsigned dummy;
        int          kind;
        logic [7:0]  a, c;
        okEntry_t    e;

        idle(3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        $display("[TB] reset released");

        // Idle after reset: first frame_start 199 cycles in, duty stays centred
        idle(250);

        // Angle 90 maps to the reset target, so duty does not move
        applyStimulus(8'h5A, 8'hA5, 1, 0);
        idle(20);

        // Angle 180: five slew steps up to 50000
        applyStimulus(8'hB4, 8'h4B, 1, 0);
        idle(PERIOD * 7);

        // Out-of-range angle and bad check are rejected; FF 00 FF obeys the
        // frame rule (0xFF == ~0x00) and loads 25000
        applyStimulus(8'hB5, 8'h4A, 1, 0);
        applyStimulus(8'h5A, 8'h00, 1, 0);
        applyStimulus(8'h00, 8'hFF, 1, 0);
        applyStimulus(8'h01, 8'hFE, 1, 0);
        idle(PERIOD * 2);

        // Resync through repeated headers, angle 45 -> 31250
        applyStimulus(8'h2D, 8'hD2, 3, 0);
        idle(PERIOD * 12);

        // Back to centre, then angle 0, then reverse to 180 after two steps
        applyStimulus(8'h5A, 8'hA5, 1, 0);
        idle(PERIOD * 4);
        applyStimulus(8'h00, 8'hFF, 1, 0);
        waitFrames(2);
        applyStimulus(8'hB4, 8'h4B, 1, 0);
        idle(PERIOD * 8);

        // Reset in the middle of CALC discards the pending command
        sendByte(8'hFF, dummy);
        sendByte(8'h2D, dummy);
        e.cycle  = cyc + 35;
        e.target = expectedTarget(45);
        okQ.push_back(e);
        sendByte(8'hD2, dummy);
        idle(10);
        pulseReset();
        idle(5);
        applyStimulus(8'h2D, 8'hD2, 1, 0);
        idle(PERIOD * 3);

        // Randomised frames with noise, resync headers and dropped bytes
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) sendByte(8'($urandom_range(0, 254)), dummy);
            case (kind)
                0, 3: begin
                    a = 8'($urandom_range(0, MAX_ANGLE));
                    c = ~a;
                end
                1: begin
                    a = 8'($urandom_range(MAX_ANGLE + 1, 254));
                    c = ~a;
                end
                default: begin
                    a = 8'($urandom_range(0, MAX_ANGLE));
                    c = ~a ^ 8'($urandom_range(1, 255));
                end
            endcase
            applyStimulus(a, c, int'($urandom_range(1, 3)),
                          (kind == 3) ? int'($urandom_range(2, 33)) : 0);
            idle(int'($urandom_range(0, 300)));
        end

        // Bounded drain of outstanding expectations
        for (int k = 0; k < 200 && (okQ.size() > 0 || errQ.size() > 0); k++) @(negedge clk);
        checkOutput("pending_cmd_ok", okQ.size(), 0);
        checkOutput("pending_cmd_error", errQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
